// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU issue/writeback stage: widths, opcodes,
// FSM states and the instruction word layout.
package cpu_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned RA_W    = 2;
   localparam int unsigned NREG    = 1 << RA_W;
   localparam int unsigned OP_W    = 3;
   localparam int unsigned FLAG_W  = 4;
   localparam int unsigned INSTR_W = 8;

   // Bit positions of the instruction fields (mirrors instr_t below)
   localparam int unsigned OP_LSB = 5;
   localparam int unsigned FO_BIT = 4;
   localparam int unsigned RD_LSB = 2;
   localparam int unsigned RS_LSB = 0;

   localparam logic [OP_W-1:0] OP_0 = 3'd0;
   localparam logic [OP_W-1:0] OP_1 = 3'd1;
   localparam logic [OP_W-1:0] OP_2 = 3'd2;
   localparam logic [OP_W-1:0] OP_3 = 3'd3;
   localparam logic [OP_W-1:0] OP_4 = 3'd4;
   localparam logic [OP_W-1:0] OP_5 = 3'd5;
   localparam logic [OP_W-1:0] OP_6 = 3'd6;
   localparam logic [OP_W-1:0] OP_7 = 3'd7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      EXEC   = 2'd2,
      WB     = 2'd3
   } state_e;

   typedef struct packed {
      logic [OP_W-1:0] op;
      logic            flag_only;
      logic [RA_W-1:0] rd;
      logic [RA_W-1:0] rs;
   } instr_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake and ALU operand/result bus of the issue stage.
interface alu_issue_ctrl_if import cpu_pkg::*; ();

   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic               instr_ready;
   logic [DATA_W-1:0]  alu_a;
   logic [DATA_W-1:0]  alu_b;
   logic [OP_W-1:0]    alu_op;
   logic [DATA_W-1:0]  alu_result;
   logic [FLAG_W-1:0]  alu_nzcv;

   modport master (
      output instr_valid, instr, alu_result, alu_nzcv,
      input  instr_ready, alu_a, alu_b, alu_op
   );

   modport slave (
      input  instr_valid, instr, alu_result, alu_nzcv,
      output instr_ready, alu_a, alu_b, alu_op
   );

endinterface

// File: rtl/alu_regfile.sv
// 4-entry register file: two operand read ports, a debug read port and one
// write port muxed between writeback and host initialisation.
module alu_regfile import cpu_pkg::*; (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_we,
   input  logic [RA_W-1:0]   wb_addr,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic              host_we,
   input  logic [RA_W-1:0]   host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   input  logic [RA_W-1:0]   ra_a,
   input  logic [RA_W-1:0]   ra_b,
   input  logic [RA_W-1:0]   dbg_addr,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b,
   output logic [DATA_W-1:0] dbg_rdata
);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];

   // Writeback has priority; the FSM never asserts both in one cycle
   always_comb begin
      regs_d = regs_q;
      if (wb_we) begin
         regs_d[wb_addr] = wb_wdata;
      end else if (host_we) begin
         regs_d[host_addr] = host_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREG); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rd_a      = regs_q[ra_a];
   assign rd_b      = regs_q[ra_b];
   assign dbg_rdata = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller around the 8-bit ALU: fixed four-cycle
// IDLE/DECODE/EXEC/WB schedule, one instruction in flight.
module alu_issue_ctrl import cpu_pkg::*; (
   input  logic              clk,
   input  logic              rst_n,
   alu_issue_ctrl_if.slave   io,
   input  logic              host_we,
   input  logic [RA_W-1:0]   host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   input  logic [RA_W-1:0]   dbg_addr,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [FLAG_W-1:0] flags,
   output logic              done
);

   state_e            state_q, state_d;
   instr_t            instr_q, instr_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [OP_W-1:0]   alu_op_q, alu_op_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [FLAG_W-1:0] nzcv_q, nzcv_d;
   logic [FLAG_W-1:0] flags_q, flags_d;
   logic              done_q, done_d;
   logic              wb_we_c;
   logic              host_we_c;
   logic [DATA_W-1:0] rd_a_c;
   logic [DATA_W-1:0] rd_b_c;

   alu_regfile u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .wb_we      (wb_we_c),
      .wb_addr    (instr_q.rd),
      .wb_wdata   (res_q),
      .host_we    (host_we_c),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .ra_a       (instr_q.rd),
      .ra_b       (instr_q.rs),
      .dbg_addr   (dbg_addr),
      .rd_a       (rd_a_c),
      .rd_b       (rd_b_c),
      .dbg_rdata  (dbg_rdata)
   );

   // Next-state and pipeline register updates
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_op_d  = alu_op_q;
      res_d     = res_q;
      nzcv_d    = nzcv_q;
      flags_d   = flags_q;
      done_d    = 1'b0;
      wb_we_c   = 1'b0;
      host_we_c = 1'b0;
      case (state_q)
         IDLE: begin
            host_we_c = host_we;
            if (io.instr_valid) begin
               instr_d = instr_t'(io.instr);
               state_d = DECODE;
            end
         end
         DECODE: begin
            alu_a_d  = rd_a_c;
            alu_b_d  = rd_b_c;
            alu_op_d = instr_q.op;
            state_d  = EXEC;
         end
         EXEC: begin
            res_d   = io.alu_result;
            nzcv_d  = io.alu_nzcv;
            done_d  = 1'b1;
            state_d = WB;
         end
         WB: begin
            flags_d = nzcv_q;
            wb_we_c = !instr_q.flag_only;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         instr_q  <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         res_q    <= '0;
         nzcv_q   <= '0;
         flags_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         res_q    <= res_d;
         nzcv_q   <= nzcv_d;
         flags_q  <= flags_d;
         done_q   <= done_d;
      end
   end

   assign io.instr_ready = (state_q == IDLE);
   assign io.alu_a       = alu_a_q;
   assign io.alu_b       = alu_b_q;
   assign io.alu_op      = alu_op_q;
   assign flags          = flags_q;
   assign done           = done_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: vector table over all opcodes plus
// backpressure, host-write collision and reset-mid-operation sequences.
module tb_alu_issue_ctrl;
   import cpu_pkg::*;

   logic              clk;
   logic              rst_n;
   logic              host_we;
   logic [RA_W-1:0]   host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic [RA_W-1:0]   dbg_addr;
   logic [DATA_W-1:0] dbg_rdata;
   logic [FLAG_W-1:0] flags;
   logic              done;

   int n_checks = 0;
   int n_pass   = 0;

   alu_issue_ctrl_if bus ();

   alu_issue_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .io         (bus),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .dbg_addr   (dbg_addr),
      .dbg_rdata  (dbg_rdata),
      .flags      (flags),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: ADD, AND, SUB(C=borrow), OR, XOR, NOT A, SHL, SHR
   logic [8:0] m_t;
   logic [7:0] m_a, m_b, m_res;
   logic       m_c, m_v;
   always_comb begin
      m_a   = bus.alu_a;
      m_b   = bus.alu_b;
      m_t   = '0;
      m_res = '0;
      m_c   = 1'b0;
      m_v   = 1'b0;
      case (bus.alu_op)
         3'd0: begin
            m_t = {1'b0, m_a} + {1'b0, m_b};
            m_res = m_t[7:0]; m_c = m_t[8];
            m_v = (m_a[7] == m_b[7]) && (m_res[7] != m_a[7]);
         end
         3'd1: m_res = m_a & m_b;
         3'd2: begin
            m_t = {1'b0, m_a} - {1'b0, m_b};
            m_res = m_t[7:0]; m_c = m_t[8];
            m_v = (m_a[7] != m_b[7]) && (m_res[7] != m_a[7]);
         end
         3'd3: m_res = m_a | m_b;
         3'd4: m_res = m_a ^ m_b;
         3'd5: m_res = ~m_a;
         3'd6: begin m_res = {m_a[6:0], 1'b0}; m_c = m_a[7]; end
         default: begin m_res = {1'b0, m_a[7:1]}; m_c = m_a[0]; end
      endcase
      bus.alu_result = m_res;
      bus.alu_nzcv   = {m_res[7], (m_res == 8'h00), m_c, m_v};
   end

   typedef struct {
      logic [2:0] op;
      logic       fo;
      logic [1:0] rd;
      logic [1:0] rs;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_res;
      logic [3:0] exp_flags;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic chk_reg(input logic [1:0] idx, input logic [7:0] exp, input string name);
      dbg_addr = idx;
      #1;
      chk(name, 32'(dbg_rdata), 32'(exp));
   endtask

   task automatic host_write(input logic [1:0] addr, input logic [7:0] data);
      @(negedge clk);
      host_we = 1'b1; host_addr = addr; host_wdata = data;
      @(posedge clk);
      #1 host_we = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] ib;
      logic [7:0] exp_b;
      logic [7:0] exp_rd;
      ib     = {v.op, v.fo, v.rd, v.rs};
      exp_b  = (v.rd == v.rs) ? v.a : v.b;
      exp_rd = v.fo ? v.a : v.exp_res;
      host_write(v.rs, v.b);
      host_write(v.rd, v.a);
      @(negedge clk);
      chk("ready_idle", 32'(bus.instr_ready), 32'(1));
      bus.instr_valid = 1'b1; bus.instr = ib;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      chk("ready_decode", 32'(bus.instr_ready), 32'(0));
      @(negedge clk);
      chk("alu_a", 32'(bus.alu_a), 32'(v.a));
      chk("alu_b", 32'(bus.alu_b), 32'(exp_b));
      chk("alu_op", 32'(bus.alu_op), 32'(v.op));
      @(negedge clk);
      chk("done_wb", 32'(done), 32'(1));
      @(negedge clk);
      chk("done_after", 32'(done), 32'(0));
      chk("flags", 32'(flags), 32'(v.exp_flags));
      chk_reg(v.rd, exp_rd, "reg_rd");
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      //           op    fo    rd    rs    a      b      res    nzcv
      vecs[0]  = '{3'd0, 1'b0, 2'd1, 2'd2, 8'h05, 8'h03, 8'h08, 4'b0000};
      vecs[1]  = '{3'd1, 1'b0, 2'd0, 2'd3, 8'hF0, 8'h3C, 8'h30, 4'b0000};
      vecs[2]  = '{3'd2, 1'b1, 2'd3, 2'd3, 8'h10, 8'h10, 8'h00, 4'b0100};
      vecs[3]  = '{3'd3, 1'b0, 2'd2, 2'd1, 8'h80, 8'h01, 8'h81, 4'b1000};
      vecs[4]  = '{3'd4, 1'b0, 2'd1, 2'd0, 8'h5A, 8'h5A, 8'h00, 4'b0100};
      vecs[5]  = '{3'd5, 1'b0, 2'd2, 2'd3, 8'h0F, 8'h77, 8'hF0, 4'b1000};
      vecs[6]  = '{3'd6, 1'b0, 2'd0, 2'd1, 8'h81, 8'h00, 8'h02, 4'b0010};
      vecs[7]  = '{3'd7, 1'b1, 2'd3, 2'd2, 8'h01, 8'h00, 8'h00, 4'b0110};
      vecs[8]  = '{3'd2, 1'b0, 2'd1, 2'd2, 8'h03, 8'h05, 8'hFE, 4'b1010};
      vecs[9]  = '{3'd0, 1'b0, 2'd0, 2'd1, 8'h7F, 8'h01, 8'h80, 4'b1001};
      vecs[10] = '{3'd0, 1'b0, 2'd2, 2'd3, 8'hFF, 8'h01, 8'h00, 4'b0110};

      rst_n = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; dbg_addr = '0;
      bus.instr_valid = 1'b0; bus.instr = '0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_ready", 32'(bus.instr_ready), 32'(1));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_flags", 32'(flags), 32'(0));
      chk("rst_alu_a", 32'(bus.alu_a), 32'(0));
      chk("rst_alu_b", 32'(bus.alu_b), 32'(0));
      chk("rst_alu_op", 32'(bus.alu_op), 32'(0));
      for (int i = 0; i < 4; i++) chk_reg(2'(i), 8'h00, "rst_reg");
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) run_vec(vecs[i]);

      // Backpressure: valid held high across two dependent instructions
      host_write(2'd1, 8'h05);
      host_write(2'd2, 8'h03);
      @(negedge clk);
      bus.instr_valid = 1'b1; bus.instr = 8'h06;
      chk("bp_ready0", 32'(bus.instr_ready), 32'(1));
      @(negedge clk);
      bus.instr = 8'h09;
      chk("bp_ready1", 32'(bus.instr_ready), 32'(0));
      @(negedge clk);
      chk("bp_ready2", 32'(bus.instr_ready), 32'(0));
      @(negedge clk);
      chk("bp_ready3", 32'(bus.instr_ready), 32'(0));
      chk("bp_done", 32'(done), 32'(1));
      @(negedge clk);
      chk("bp_ready4", 32'(bus.instr_ready), 32'(1));
      chk_reg(2'd1, 8'h08, "bp_r1");
      @(negedge clk);
      bus.instr_valid = 1'b0;
      @(negedge clk);
      chk("bp_alu_a", 32'(bus.alu_a), 32'(8'h03));
      chk("bp_alu_b", 32'(bus.alu_b), 32'(8'h08));
      repeat (2) @(negedge clk);
      chk_reg(2'd2, 8'h0B, "bp_r2");

      // Host write in the accept cycle is seen; host write during EXEC is dropped
      host_write(2'd3, 8'h33);
      @(negedge clk);
      host_we = 1'b1; host_addr = 2'd2; host_wdata = 8'hAA;
      bus.instr_valid = 1'b1; bus.instr = 8'h06;
      @(negedge clk);
      host_we = 1'b0; bus.instr_valid = 1'b0;
      @(negedge clk);
      chk("col_alu_b", 32'(bus.alu_b), 32'(8'hAA));
      chk("col_alu_a", 32'(bus.alu_a), 32'(8'h08));
      host_we = 1'b1; host_addr = 2'd3; host_wdata = 8'h55;
      @(negedge clk);
      host_we = 1'b0;
      @(negedge clk);
      chk_reg(2'd3, 8'h33, "col_drop_r3");
      chk_reg(2'd1, 8'hB2, "col_r1");
      chk("col_flags", 32'(flags), 32'(4'b1000));

      // Reset asserted mid-EXEC aborts the instruction
      @(negedge clk);
      bus.instr_valid = 1'b1; bus.instr = 8'h06;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      @(negedge clk);
      chk("mid_alu_a_pre", 32'(bus.alu_a), 32'(8'hB2));
      rst_n = 1'b0;
      #1;
      chk("mid_flags", 32'(flags), 32'(0));
      chk("mid_done", 32'(done), 32'(0));
      chk("mid_ready", 32'(bus.instr_ready), 32'(1));
      chk("mid_alu_a", 32'(bus.alu_a), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid_no_done", 32'(done), 32'(0));
      end
      chk("mid_flags_after", 32'(flags), 32'(0));
      for (int i = 0; i < 4; i++) chk_reg(2'(i), 8'h00, "mid_reg");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/writeback stage wrapped around the 8-bit ALU.
- Accepts one 8-bit instruction per handshake, reads two operands from an internal 4-entry register file, and drives the ALU's A, B and OP_Code inputs.
- Captures the ALU's result and NZCV flags, then writes them back to the register file and a flag register.
- Multi-cycle with a fixed schedule: one instruction in flight at a time.

Parameters:
- DATA_W, 8, operand/result/register width (must match the ALU).
- RA_W, 2, register address width; register count is 2**RA_W = 4.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction present on instr.
- instr  in  8  [7:5] op, [4] flag_only, [3:2] rd (dest and A source), [1:0] rs (B source).
- instr_ready  out  1  block can accept an instruction.
- host_we  in  1  host register write strobe (register initialisation).
- host_addr  in  RA_W  host write address.
- host_wdata  in  DATA_W  host write data.
- dbg_addr  in  RA_W  debug read address.
- dbg_rdata  out  DATA_W  combinational read of R[dbg_addr].
- alu_a  out  DATA_W  to ALU A.
- alu_b  out  DATA_W  to ALU B.
- alu_op  out  3  to ALU OP_Code.
- alu_result  in  DATA_W  from ALU Result.
- alu_nzcv  in  4  from ALU NZCV.
- flags  out  4  architectural NZCV register.
- done  out  1  one-cycle pulse at writeback.

Behaviour:
- Reset (async assert, removal synchronous to clk):
  - state=IDLE; R[0..3]=0x00; flags=4'b0000.
  - alu_a=alu_b=0x00; alu_op=3'b000; done=0; instr_reg=0x00.
  - instr_ready=1 (decoded from IDLE).
- FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE.
  - IDLE: instr_ready=1. On instr_valid & instr_ready, latch instr into instr_reg and go to DECODE. Otherwise stay.
  - DECODE: register alu_a=R[rd], alu_b=R[rs], alu_op=op. Go to EXEC.
  - EXEC: ALU is combinational. Capture alu_result and alu_nzcv into internal res_q/nzcv_q. Go to WB.
  - WB: flags<=nzcv_q always. If flag_only=0, R[rd]<=res_q; if flag_only=1, no register write. done=1 for exactly this cycle. Go to IDLE.
- Latency and throughput:
  - Handshake accept edge = cycle 0; done high in cycle 3; the written register is visible on dbg_rdata in cycle 4.
  - Throughput is one instruction per 4 cycles.
- instr_ready is low in DECODE/EXEC/WB. instr_valid there is ignored; the instruction is not consumed and the upstream must hold it.
- alu_a/alu_b/alu_op hold their last value outside DECODE (no glitching to 0).
- rd==rs is legal: both operands equal R[rd].
- Host writes:
  - Honoured only in IDLE; ignored (dropped) in any other state.
  - A host write in the same IDLE cycle as an instruction accept commits on that edge, so the accepted instruction reads the new value in DECODE.
- Back-to-back dependency: an instruction accepted in the IDLE cycle right after WB sees the written-back value.
- No arithmetic in this block; widths pass through unchanged.
- Reset mid-operation: the in-flight instruction is aborted with no writeback, no flag update and no done; all state returns to reset values.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W.
  - Opcode localparams OP_0..OP_7, matching the ALU encoding.
  - State enum IDLE/DECODE/EXEC/WB.
  - Instruction field bit positions.
- One sub-module: alu_regfile. It has 4xDATA_W registers, 2 synchronous-use read ports plus the debug read port, and one write port. The write mux selects WB over host (never simultaneous by construction).
- The top level holds the FSM, pipeline registers and flag register.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC -> flags=0, done never pulses, all R=0x00, instr_ready=1.
- Basic ADD-style: host writes R1=0x05, R2=0x03; issue instr=0x06 (op=000, flag_only=0, rd=1, rs=2).
  - Required: alu_a=0x05, alu_b=0x03, alu_op=000 in EXEC.
  - Bench ALU model returns 0x08/0000 -> done at cycle 3, R1=0x08, flags=0000.
- Flag-only: R3=0x10, issue instr=0x5F (op=010, flag_only=1, rd=3, rs=3); model returns 0x00/0100 -> flags=0100, R3 stays 0x10.
- Backpressure: hold instr_valid=1 continuously with two different instructions.
  - instr_ready is high only every 4th cycle.
  - Second instruction is accepted exactly in the IDLE cycle after the first's WB and reads the first's result.
- Host write collision: host_we with addr=2, data=0xAA in the same cycle as the accept of rs=2 -> alu_b=0xAA. A host_we during EXEC is dropped, and R is unchanged.
- Opcode sweep: all op values 000..111 appear on alu_op unmodified.
